// File: rtl/ovl_fire_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ovl_fire_pkg
//  Brief    : Shared helpers, report record and FSM encoding for the OVL
//             fire collector.
//  Revision : 1.0  initial release
// ============================================================================
package ovl_fire_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int DEF_IDX_WIDTH = 3;
    localparam int DEF_TS_WIDTH  = 32;

    // Report record at the default configuration (8 checkers, 32-bit stamp).
    typedef struct packed {
        logic [DEF_IDX_WIDTH-1:0] idx;
        logic [DEF_TS_WIDTH-1:0]  ts;
    } rpt_rec_t;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } rpt_state_e;

endpackage
`default_nettype wire

// File: rtl/ovl_fire_collector_if.sv
`default_nettype none
// ============================================================================
//  Module   : ovl_fire_collector_if
//  Brief    : Valid/ready report stream carrying checker index and timestamp.
//  Revision : 1.0  initial release
// ============================================================================
interface ovl_fire_collector_if
    import ovl_fire_pkg::*;
#(
    parameter int NUM_CHECKERS = 8,
    parameter int TS_WIDTH     = 32
);
    localparam int IDX_W = clog2(NUM_CHECKERS);

    logic                rpt_valid;
    logic                rpt_ready;
    logic [IDX_W-1:0]    rpt_idx;
    logic [TS_WIDTH-1:0] rpt_time;

    modport master (output rpt_valid, output rpt_idx, output rpt_time, input  rpt_ready);
    modport slave  (input  rpt_valid, input  rpt_idx, input  rpt_time, output rpt_ready);

endinterface
`default_nettype wire

// File: rtl/ovl_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ovl_rr_arbiter
//  Brief    : Combinational round-robin pick of the lowest request at or
//             above the pointer, wrapping around.
//  Revision : 1.0  initial release
// ============================================================================
module ovl_rr_arbiter
    import ovl_fire_pkg::*;
#(
    parameter  int N  = 8,
    localparam int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] w_pos;

    always_comb begin
        gnt_valid = 1'b0;
        gnt       = '0;
        gnt_idx   = '0;
        w_pos     = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = IW'((int'(ptr) + k) % N);
            if (!gnt_valid && req[w_pos]) begin
                gnt_valid    = 1'b1;
                gnt[w_pos]   = 1'b1;
                gnt_idx      = w_pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ovl_fire_collector.sv
`default_nettype none
// ============================================================================
//  Module   : ovl_fire_collector
//  Brief    : Serialises per-checker fire pulses into a timestamped report
//             stream; keeps fire/drop counts, first failure, fatal, budget.
//  Revision : 1.0  initial release
// ============================================================================
module ovl_fire_collector
    import ovl_fire_pkg::*;
#(
    parameter  int                      NUM_CHECKERS = 8,
    parameter  int                      CNT_WIDTH    = 16,
    parameter  int                      TS_WIDTH     = 32,
    parameter  int                      MAX_REPORT   = 16,
    parameter  logic [NUM_CHECKERS-1:0] FATAL_MASK   = '0,
    localparam int                      IDX_W        = clog2(NUM_CHECKERS)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    clear,
    input  logic [NUM_CHECKERS-1:0] fire,
    ovl_fire_collector_if.master    rpt,
    output logic [CNT_WIDTH-1:0]    fire_count,
    output logic [CNT_WIDTH-1:0]    drop_count,
    output logic                    first_valid,
    output logic [IDX_W-1:0]        first_idx,
    output logic                    fatal,
    output logic                    budget_done
);

    localparam int RC_W  = (clog2(MAX_REPORT + 1) < 1) ? 1 : clog2(MAX_REPORT + 1);
    localparam int SUM_W = CNT_WIDTH + IDX_W + 1;

    localparam logic [IDX_W-1:0]    C_LAST_IDX = IDX_W'(NUM_CHECKERS - 1);
    localparam logic [IDX_W-1:0]    C_ONE_IDX  = IDX_W'(1);
    localparam logic [IDX_W:0]      C_ONE_POP  = (IDX_W + 1)'(1);
    localparam logic [RC_W-1:0]     C_ONE_RC   = RC_W'(1);
    localparam logic [RC_W-1:0]     C_MAX_RC   = RC_W'(MAX_REPORT);
    localparam logic [TS_WIDTH-1:0] C_ONE_TS   = TS_WIDTH'(1);

    typedef struct packed {
        logic [IDX_W-1:0]    idx;
        logic [TS_WIDTH-1:0] ts;
    } rec_t;

    rpt_state_e              state_q, state_d;
    rec_t                    rpt_q, rpt_d;
    logic [TS_WIDTH-1:0]     ts_q, ts_d;
    logic [TS_WIDTH-1:0]     ts_reg_q [NUM_CHECKERS];
    logic [TS_WIDTH-1:0]     ts_reg_d [NUM_CHECKERS];
    logic [NUM_CHECKERS-1:0] pending_q, pending_d;
    logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [RC_W-1:0]         rpt_cnt_q, rpt_cnt_d;
    logic [CNT_WIDTH-1:0]    fire_count_q, fire_count_d;
    logic [CNT_WIDTH-1:0]    drop_count_q, drop_count_d;
    logic                    first_valid_q, first_valid_d;
    logic [IDX_W-1:0]        first_idx_q, first_idx_d;
    logic                    fatal_q, fatal_d;
    logic                    budget_done_q, budget_done_d;

    logic [NUM_CHECKERS-1:0] w_sampled;
    logic                    w_accept;
    logic [NUM_CHECKERS-1:0] w_pending_nxt;
    logic [TS_WIDTH-1:0]     w_ts_reg_nxt [NUM_CHECKERS];
    logic [IDX_W:0]          w_fire_pop;
    logic [IDX_W:0]          w_drop_pop;
    logic [SUM_W-1:0]        w_fire_sum;
    logic [SUM_W-1:0]        w_drop_sum;
    logic [IDX_W-1:0]        w_low_idx;
    logic [TS_WIDTH-1:0]     w_gnt_ts;
    logic                    w_gnt_valid;
    logic [NUM_CHECKERS-1:0] w_gnt_onehot;
    logic [IDX_W-1:0]        w_gnt_idx;

    // Arbitrating over next-cycle pending lets a fire at t be presented at t+1.
    ovl_rr_arbiter #(
        .N (NUM_CHECKERS)
    ) u_arb (
        .req       (w_pending_nxt),
        .ptr       (rr_ptr_q),
        .gnt_valid (w_gnt_valid),
        .gnt       (w_gnt_onehot),
        .gnt_idx   (w_gnt_idx)
    );

    always_comb begin
        w_sampled     = enable ? fire : '0;
        w_accept      = (state_q == ST_PRESENT) && rpt.rpt_ready;
        w_pending_nxt = pending_q;
        w_ts_reg_nxt  = ts_reg_q;
        w_fire_pop    = '0;
        w_drop_pop    = '0;
        w_low_idx     = '0;

        if (w_accept) begin
            w_pending_nxt[rpt_q.idx] = 1'b0;
        end
        for (int i = 0; i < NUM_CHECKERS; i++) begin
            if (w_sampled[i]) begin
                w_fire_pop = w_fire_pop + C_ONE_POP;
                // A refire on the entry being accepted starts a fresh report.
                if (!pending_q[i] || (w_accept && (rpt_q.idx == IDX_W'(i)))) begin
                    w_pending_nxt[i] = 1'b1;
                    w_ts_reg_nxt[i]  = ts_q;
                end else begin
                    w_drop_pop = w_drop_pop + C_ONE_POP;
                end
            end
        end
        for (int i = NUM_CHECKERS - 1; i >= 0; i--) begin
            if (w_sampled[i]) begin
                w_low_idx = IDX_W'(i);
            end
        end

        w_fire_sum   = SUM_W'(fire_count_q) + SUM_W'(w_fire_pop);
        w_drop_sum   = SUM_W'(drop_count_q) + SUM_W'(w_drop_pop);
        fire_count_d = (|w_fire_sum[SUM_W-1:CNT_WIDTH]) ? '1 : w_fire_sum[CNT_WIDTH-1:0];
        drop_count_d = (|w_drop_sum[SUM_W-1:CNT_WIDTH]) ? '1 : w_drop_sum[CNT_WIDTH-1:0];

        ts_d          = ts_q + C_ONE_TS;
        pending_d     = w_pending_nxt;
        ts_reg_d      = w_ts_reg_nxt;
        first_valid_d = first_valid_q;
        first_idx_d   = first_idx_q;
        if (!first_valid_q && (w_sampled != '0)) begin
            first_valid_d = 1'b1;
            first_idx_d   = w_low_idx;
        end
        fatal_d = fatal_q | (|(w_sampled & FATAL_MASK));

        w_gnt_ts = '0;
        for (int i = 0; i < NUM_CHECKERS; i++) begin
            w_gnt_ts = w_gnt_ts | (w_ts_reg_nxt[i] & {TS_WIDTH{w_gnt_onehot[i]}});
        end

        state_d       = state_q;
        rpt_d         = rpt_q;
        rr_ptr_d      = rr_ptr_q;
        rpt_cnt_d     = rpt_cnt_q;
        budget_done_d = budget_done_q;
        case (state_q)
            ST_IDLE: begin
                if (w_gnt_valid && !budget_done_q) begin
                    state_d   = ST_PRESENT;
                    rpt_d.idx = w_gnt_idx;
                    rpt_d.ts  = w_gnt_ts;
                end
            end
            ST_PRESENT: begin
                if (w_accept) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (rpt_q.idx == C_LAST_IDX) ? '0 : rpt_q.idx + C_ONE_IDX;
                    if (MAX_REPORT != 0) begin
                        rpt_cnt_d = rpt_cnt_q + C_ONE_RC;
                        if (rpt_cnt_d == C_MAX_RC) begin
                            budget_done_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Clear overrides fire and accept in the same cycle; the timestamp runs on.
        if (clear) begin
            pending_d     = '0;
            fire_count_d  = '0;
            drop_count_d  = '0;
            first_valid_d = 1'b0;
            first_idx_d   = '0;
            fatal_d       = 1'b0;
            budget_done_d = 1'b0;
            rr_ptr_d      = '0;
            rpt_cnt_d     = '0;
            state_d       = ST_IDLE;
            rpt_d         = '0;
            for (int i = 0; i < NUM_CHECKERS; i++) begin
                ts_reg_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            rpt_q         <= '0;
            ts_q          <= '0;
            pending_q     <= '0;
            rr_ptr_q      <= '0;
            rpt_cnt_q     <= '0;
            fire_count_q  <= '0;
            drop_count_q  <= '0;
            first_valid_q <= 1'b0;
            first_idx_q   <= '0;
            fatal_q       <= 1'b0;
            budget_done_q <= 1'b0;
            for (int i = 0; i < NUM_CHECKERS; i++) begin
                ts_reg_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            rpt_q         <= rpt_d;
            ts_q          <= ts_d;
            pending_q     <= pending_d;
            rr_ptr_q      <= rr_ptr_d;
            rpt_cnt_q     <= rpt_cnt_d;
            fire_count_q  <= fire_count_d;
            drop_count_q  <= drop_count_d;
            first_valid_q <= first_valid_d;
            first_idx_q   <= first_idx_d;
            fatal_q       <= fatal_d;
            budget_done_q <= budget_done_d;
            for (int i = 0; i < NUM_CHECKERS; i++) begin
                ts_reg_q[i] <= ts_reg_d[i];
            end
        end
    end

    assign rpt.rpt_valid = (state_q == ST_PRESENT);
    assign rpt.rpt_idx   = rpt_q.idx;
    assign rpt.rpt_time  = rpt_q.ts;
    assign fire_count    = fire_count_q;
    assign drop_count    = drop_count_q;
    assign first_valid   = first_valid_q;
    assign first_idx     = first_idx_q;
    assign fatal         = fatal_q;
    assign budget_done   = budget_done_q;

endmodule
`default_nettype wire

// File: tb/tb_ovl_fire_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ovl_fire_collector
//  Brief    : Directed self-checking bench; dut_a uses the default budget with
//             checker 4 fatal, dut_b a 2-report budget and 4-bit counters.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ovl_fire_collector;
    import ovl_fire_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        clear_a, clear_b;
    logic [7:0]  fire_a, fire_b;
    logic [15:0] fire_count_a, drop_count_a;
    logic [3:0]  fire_count_b, drop_count_b;
    logic        first_valid_a, first_valid_b;
    logic [2:0]  first_idx_a, first_idx_b;
    logic        fatal_a, fatal_b;
    logic        budget_done_a, budget_done_b;

    int       n_checks = 0;
    int       n_pass   = 0;
    int       cyc;
    int       t0;
    int       n_acc;
    int       acc_idx [8];
    rpt_rec_t exp_rec;

    ovl_fire_collector_if #(.NUM_CHECKERS(8), .TS_WIDTH(32)) if_a ();
    ovl_fire_collector_if #(.NUM_CHECKERS(8), .TS_WIDTH(32)) if_b ();

    ovl_fire_collector #(
        .NUM_CHECKERS (8), .CNT_WIDTH (16), .TS_WIDTH (32),
        .MAX_REPORT   (16), .FATAL_MASK (8'h10)
    ) u_dut_a (
        .clk (clk), .reset_n (reset_n), .enable (enable), .clear (clear_a),
        .fire (fire_a), .rpt (if_a),
        .fire_count (fire_count_a), .drop_count (drop_count_a),
        .first_valid (first_valid_a), .first_idx (first_idx_a),
        .fatal (fatal_a), .budget_done (budget_done_a)
    );

    ovl_fire_collector #(
        .NUM_CHECKERS (8), .CNT_WIDTH (4), .TS_WIDTH (32),
        .MAX_REPORT   (2), .FATAL_MASK (8'h00)
    ) u_dut_b (
        .clk (clk), .reset_n (reset_n), .enable (enable), .clear (clear_b),
        .fire (fire_b), .rpt (if_b),
        .fire_count (fire_count_b), .drop_count (drop_count_b),
        .first_valid (first_valid_b), .first_idx (first_idx_b),
        .fatal (fatal_b), .budget_done (budget_done_b)
    );

    always #5 clk = ~clk;

    // Reference cycle count: equals the expected timestamp within a cycle.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic pulse_clear_a();
        @(negedge clk); clear_a = 1'b1;
        @(negedge clk); clear_a = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1; clear_a = 1'b0; clear_b = 1'b0;
        fire_a = '0; fire_b = '0;
        if_a.rpt_ready = 1'b1; if_b.rpt_ready = 1'b1;

        @(negedge clk);
        chk("rst_valid_a", if_a.rpt_valid, 0);
        chk("rst_fcnt_a",  fire_count_a, 0);
        chk("rst_dcnt_a",  drop_count_a, 0);
        chk("rst_first_a", first_valid_a, 0);
        chk("rst_fatal_a", fatal_a, 0);
        chk("rst_budget_b", budget_done_b, 0);
        @(negedge clk); reset_n = 1'b1;

        // 1: single fire on checker 3 at cycle 10
        while (cyc != 10) @(negedge clk);
        fire_a = 8'h08;
        exp_rec.idx = 3'd3; exp_rec.ts = 32'd10;
        @(negedge clk); fire_a = '0;
        chk("t1_valid", if_a.rpt_valid, 1);
        chk("t1_idx",   if_a.rpt_idx, exp_rec.idx);
        chk("t1_time",  if_a.rpt_time, exp_rec.ts);
        @(negedge clk);
        chk("t1_bubble",   if_a.rpt_valid, 0);
        chk("t1_fcnt",     fire_count_a, 1);
        chk("t1_first_v",  first_valid_a, 1);
        chk("t1_first_i",  first_idx_a, 3);

        // 2: three bits in one cycle, reported round-robin from index 0
        pulse_clear_a();
        @(negedge clk); fire_a = 8'b1000_0101;
        n_acc = 0;
        for (int k = 0; k < 8; k++) acc_idx[k] = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) fire_a = '0;
            if (if_a.rpt_valid && if_a.rpt_ready) begin
                if (n_acc < 8) acc_idx[n_acc] = int'(if_a.rpt_idx);
                n_acc++;
            end
        end
        chk("t2_nacc", n_acc, 3);
        chk("t2_idx0", acc_idx[0], 0);
        chk("t2_idx1", acc_idx[1], 2);
        chk("t2_idx2", acc_idx[2], 7);
        chk("t2_fcnt", fire_count_a, 3);

        // 3: stalled consumer, repeated fire on checker 5 keeps oldest stamp
        pulse_clear_a();
        if_a.rpt_ready = 1'b0;
        @(negedge clk); fire_a = 8'h20; t0 = cyc;
        @(negedge clk); fire_a = '0;
        chk("t3_valid", if_a.rpt_valid, 1);
        chk("t3_idx",   if_a.rpt_idx, 5);
        chk("t3_time",  if_a.rpt_time, 32'(t0));
        @(negedge clk); fire_a = 8'h20;
        @(negedge clk); fire_a = '0;
        @(negedge clk); fire_a = 8'h20;
        @(negedge clk); fire_a = '0;
        chk("t3_valid_hold", if_a.rpt_valid, 1);
        chk("t3_idx_hold",   if_a.rpt_idx, 5);
        chk("t3_time_hold",  if_a.rpt_time, 32'(t0));
        chk("t3_dcnt",       drop_count_a, 2);
        chk("t3_fcnt",       fire_count_a, 3);
        if_a.rpt_ready = 1'b1;
        @(negedge clk);
        chk("t3_accepted", if_a.rpt_valid, 0);
        repeat (3) @(negedge clk);
        chk("t3_no_repeat", if_a.rpt_valid, 0);

        // 5: fatal checker, then clear colliding with a fire
        pulse_clear_a();
        if_a.rpt_ready = 1'b0;
        @(negedge clk); fire_a = 8'h10;
        @(negedge clk); fire_a = '0;
        chk("t5_fatal", fatal_a, 1);
        @(negedge clk); clear_a = 1'b1; fire_a = 8'h10;
        @(negedge clk); clear_a = 1'b0; fire_a = '0;
        chk("t5_fatal_clr", fatal_a, 0);
        chk("t5_fcnt_clr",  fire_count_a, 0);
        chk("t5_dcnt_clr",  drop_count_a, 0);
        chk("t5_first_clr", first_valid_a, 0);
        chk("t5_valid_clr", if_a.rpt_valid, 0);
        repeat (3) @(negedge clk);
        chk("t5_no_report", if_a.rpt_valid, 0);

        // 4: report budget of two on dut_b
        @(negedge clk); fire_b = 8'h1F;
        n_acc = 0;
        for (int k = 0; k < 8; k++) acc_idx[k] = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 0) fire_b = '0;
            if (if_b.rpt_valid && if_b.rpt_ready) begin
                if (n_acc < 8) acc_idx[n_acc] = int'(if_b.rpt_idx);
                n_acc++;
            end
        end
        chk("t4_nacc",   n_acc, 2);
        chk("t4_idx0",   acc_idx[0], 0);
        chk("t4_idx1",   acc_idx[1], 1);
        chk("t4_budget", budget_done_b, 1);
        chk("t4_valid",  if_b.rpt_valid, 0);
        chk("t4_fcnt",   fire_count_b, 5);

        // 6b: 4-bit counter saturation (3 of the 8 first-cycle fires already pending)
        @(negedge clk); fire_b = 8'hFF;
        @(negedge clk); fire_b = 8'hFF;
        @(negedge clk); fire_b = '0;
        chk("t6_fcnt_sat", fire_count_b, 15);
        chk("t6_dcnt",     drop_count_b, 11);
        @(negedge clk); fire_b = 8'hFF;
        @(negedge clk); fire_b = '0;
        chk("t6_dcnt_sat", drop_count_b, 15);

        // 6a: asynchronous reset while a report is presented
        if_a.rpt_ready = 1'b0;
        @(negedge clk); fire_a = 8'h02;
        @(negedge clk); fire_a = '0;
        chk("t6_valid_pre", if_a.rpt_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_valid_rst",  if_a.rpt_valid, 0);
        chk("t6_fcnt_rst",   fire_count_a, 0);
        chk("t6_first_rst",  first_valid_a, 0);
        chk("t6_budget_rst", budget_done_b, 0);
        chk("t6_fcnt_b_rst", fire_count_b, 0);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
